// File: rtl/mp_cache.sv
// Store-and-forward packet buffer: framed words are held in RAM and a packet
// is only released to the read side once its eop word has been stored.
module mp_cache #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int AF_MARGIN = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ready,
  output logic              rd_sop,
  output logic              rd_eop,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = DATA_W + 2;
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_MARGIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  wr_state_t state, state_nxt;

  logic [WW-1:0] mem [DEPTH];

  // wr_ptr: next free slot; pkt_start: first word of the open packet;
  // commit_ptr: one past the last committed eop; rd_ptr frees a slot only
  // when its word leaves the output register; fetch_ptr is the RAM read address.
  logic [AW:0] wr_ptr, wr_ptr_nxt;
  logic [AW:0] pkt_start, pkt_start_nxt;
  logic [AW:0] commit_ptr, commit_ptr_nxt;
  logic [AW:0] rd_ptr, rd_ptr_nxt;
  logic [AW:0] fetch_ptr;
  logic [AW:0] pkt_cnt;
  logic [AW:0] base;
  logic [AW:0] count_nxt;
  logic        base_full;
  logic        store;
  logic        commit;

  logic          s1_vld;
  logic [WW-1:0] s1_word;
  logic          xfer;
  logic          out_load;
  logic          avail;
  logic          fetch;
  logic          eop_load;

  // A restarting sop reuses the slot of the abandoned packet's first word.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    pkt_start_nxt  = pkt_start;
    commit_ptr_nxt = commit_ptr;
    store          = 1'b0;
    commit         = 1'b0;
    base           = (state == PKT && wr_sop) ? pkt_start : wr_ptr;
    base_full      = ((base - rd_ptr) == FULL_CNT);
    case (state)
      IDLE, PKT: begin
        if (wr_vld && (wr_sop || state == PKT)) begin
          if (base_full) begin
            wr_ptr_nxt = (state == PKT) ? pkt_start : wr_ptr;
            state_nxt  = wr_eop ? IDLE : DROP;
          end else begin
            store      = 1'b1;
            wr_ptr_nxt = base + ONE;
            if (wr_sop) pkt_start_nxt = base;
            if (wr_eop) begin
              commit         = 1'b1;
              commit_ptr_nxt = base + ONE;
              state_nxt      = IDLE;
            end else begin
              state_nxt = PKT;
            end
          end
        end
      end
      DROP: begin
        if (wr_vld && wr_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer       = rd_vld && ready;
  assign out_load   = s1_vld && (!rd_vld || ready);
  assign avail      = (pkt_cnt != '0) && (fetch_ptr != commit_ptr);
  assign fetch      = avail && (!s1_vld || out_load);
  assign eop_load   = out_load && s1_word[DATA_W];
  assign rd_ptr_nxt = xfer ? rd_ptr + ONE : rd_ptr;
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      pkt_start  <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      pkt_start  <= pkt_start_nxt;
      commit_ptr <= commit_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
    end
  end

  // Flags come from next-state pointers, so a simultaneous write and read
  // leaves them untouched instead of pulsing.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      full        <= (count_nxt == FULL_CNT);
      almost_full <= ((FULL_CNT - count_nxt) <= AF_CNT);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit, eop_load})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (store) mem[base[AW-1:0]] <= {wr_sop, wr_eop, wr_data};
    if (fetch) s1_word <= mem[fetch_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_ptr <= '0;
      s1_vld    <= 1'b0;
      rd_vld    <= 1'b0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (fetch) begin
        fetch_ptr <= fetch_ptr + ONE;
        s1_vld    <= 1'b1;
      end else if (out_load) begin
        s1_vld <= 1'b0;
      end
      if (out_load) begin
        rd_vld  <= 1'b1;
        rd_sop  <= s1_word[DATA_W+1];
        rd_eop  <= s1_word[DATA_W];
        rd_data <= s1_word[DATA_W-1:0];
      end else if (ready) begin
        rd_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mp_cache.sv
// Directed bench for mp_cache: latency, backpressure, fill/overflow, single-word
// packets, sop abort and asynchronous reset mid-packet.
module tb_mp_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_sop = 1'b0;
  logic        wr_eop = 1'b0;
  logic        wr_vld = 1'b0;
  logic [31:0] wr_data = '0;
  logic        ready = 1'b0;
  logic        rd_sop;
  logic        rd_eop;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic        full;
  logic        almost_full;

  int errors = 0;
  int checks = 0;
  logic [33:0] rx_q [$];

  mp_cache #(.DATA_W(32), .DEPTH(256), .AF_MARGIN(8)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .wr_sop      (wr_sop),
    .wr_eop      (wr_eop),
    .wr_vld      (wr_vld),
    .wr_data     (wr_data),
    .ready       (ready),
    .rd_sop      (rd_sop),
    .rd_eop      (rd_eop),
    .rd_vld      (rd_vld),
    .rd_data     (rd_data),
    .full        (full),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  // Every accepted read word, in order, as {sop, eop, data}.
  always @(negedge clk) begin
    if (rst_n && rd_vld && ready) rx_q.push_back({rd_sop, rd_eop, rd_data});
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic sop, input logic eop, input logic [31:0] data);
    wr_vld  = 1'b1;
    wr_sop  = sop;
    wr_eop  = eop;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_vld = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
  endtask

  task automatic waitRx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      idle(1);
      c++;
    end
  endtask

  task automatic checkOutputs(input string tag, input logic vld, input logic sop,
                              input logic eop, input logic [31:0] data);
    checkOutput({tag, "_vld"}, 32'(rd_vld), 32'(vld));
    if (vld) begin
      checkOutput({tag, "_sop"}, 32'(rd_sop), 32'(sop));
      checkOutput({tag, "_eop"}, 32'(rd_eop), 32'(eop));
      checkOutput({tag, "_data"}, rd_data, data);
    end
  endtask

  initial begin
    int bad;
    int eops;

    // Reset values
    #2;
    checkOutput("rst_vld", 32'(rd_vld), 32'd0);
    checkOutput("rst_sop", 32'(rd_sop), 32'd0);
    checkOutput("rst_eop", 32'(rd_eop), 32'd0);
    checkOutput("rst_data", rd_data, 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_af", 32'(almost_full), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Test 1: 4-word packet, ready high, first rd_vld two edges after eop
    $display("[TB] test 1: basic packet");
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(i == 1, i == 4, 32'(i));
    checkOutput("t1_lat0", 32'(rd_vld), 32'd0);
    idle(1);
    checkOutput("t1_lat1", 32'(rd_vld), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      checkOutputs($sformatf("t1_w%0d", k), 1'b1, k == 1, k == 4, 32'(k));
    end
    idle(1);
    checkOutput("t1_end_vld", 32'(rd_vld), 32'd0);

    // Test 2: backpressure holds the first word stable
    $display("[TB] test 2: backpressure");
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(i == 1, i == 4, 32'h10 + 32'(i));
    idle(3);
    for (int k = 0; k < 3; k++) begin
      checkOutputs($sformatf("t2_hold%0d", k), 1'b1, 1'b1, 1'b0, 32'h11);
      idle(1);
    end
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutputs($sformatf("t2_w%0d", k), 1'b1, k == 1, k == 4, 32'h10 + 32'(k));
      idle(1);
    end
    checkOutput("t2_end_vld", 32'(rd_vld), 32'd0);

    // Test 3: fill to DEPTH with ready low, watch the occupancy flags
    $display("[TB] test 3: fill");
    ready = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(i % 4 == 0, i % 4 == 3, 32'h1000 + 32'(i));
      if (i == 246) checkOutput("t3_af_247", 32'(almost_full), 32'd0);
      if (i == 247) checkOutput("t3_af_248", 32'(almost_full), 32'd1);
      if (i == 247) checkOutput("t3_full_248", 32'(full), 32'd0);
      if (i == 254) checkOutput("t3_full_255", 32'(full), 32'd0);
      if (i == 255) checkOutput("t3_full_256", 32'(full), 32'd1);
    end

    // Test 4: a packet written while full vanishes completely
    $display("[TB] test 4: overflow drop and drain");
    for (int i = 0; i < 3; i++) applyStimulus(i == 0, i == 2, 32'hDEAD_0000 + 32'(i));
    checkOutput("t4_full_kept", 32'(full), 32'd1);
    ready = 1'b1;
    waitRx(256, 700);
    idle(6);
    checkOutput("t4_words", 32'(rx_q.size()), 32'd256);
    bad = 0;
    eops = 0;
    foreach (rx_q[j]) begin
      if (rx_q[j][32]) eops++;
      if (rx_q[j] !== {j % 4 == 0, j % 4 == 3, 32'h1000 + 32'(j)}) bad++;
    end
    checkOutput("t4_bad_words", 32'(bad), 32'd0);
    checkOutput("t4_pkts", 32'(eops), 32'd64);
    checkOutput("t4_full_drain", 32'(full), 32'd0);
    checkOutput("t4_af_drain", 32'(almost_full), 32'd0);

    // Test 5: single-word packet
    $display("[TB] test 5: single word");
    applyStimulus(1'b1, 1'b1, 32'hA5);
    idle(1);
    checkOutput("t5_lat", 32'(rd_vld), 32'd0);
    idle(1);
    checkOutputs("t5_w", 1'b1, 1'b1, 1'b1, 32'hA5);
    idle(1);
    checkOutput("t5_end_vld", 32'(rd_vld), 32'd0);

    // Test 6: sop abort, then async reset in the middle of a packet
    $display("[TB] test 6: abort and reset");
    rx_q.delete();
    applyStimulus(1'b1, 1'b0, 32'hA1);
    applyStimulus(1'b0, 1'b0, 32'hA2);
    applyStimulus(1'b1, 1'b0, 32'hB1);
    applyStimulus(1'b0, 1'b0, 32'hB2);
    applyStimulus(1'b0, 1'b1, 32'hB3);
    idle(8);
    checkOutput("t6_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      checkOutput("t6_b1", 32'(rx_q[0]), 32'(34'h2_0000_00B1));
      checkOutput("t6_b1_flags", 32'(rx_q[0][33:32]), 32'd2);
      checkOutput("t6_b2", rx_q[1][31:0], 32'hB2);
      checkOutput("t6_b2_flags", 32'(rx_q[1][33:32]), 32'd0);
      checkOutput("t6_b3", rx_q[2][31:0], 32'hB3);
      checkOutput("t6_b3_flags", 32'(rx_q[2][33:32]), 32'd1);
    end
    ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'hC1);
    applyStimulus(1'b0, 1'b1, 32'hC2);
    applyStimulus(1'b1, 1'b0, 32'hD1);
    applyStimulus(1'b0, 1'b0, 32'hD2);
    idle(2);
    checkOutput("t6_pre_rst_vld", 32'(rd_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_vld", 32'(rd_vld), 32'd0);
    checkOutput("t6_rst_data", rd_data, 32'd0);
    checkOutput("t6_rst_sop", 32'(rd_sop), 32'd0);
    checkOutput("t6_rst_eop", 32'(rd_eop), 32'd0);
    idle(2);
    rst_n = 1'b1;
    rx_q.delete();
    ready = 1'b1;
    idle(8);
    checkOutput("t6_post_vld", 32'(rd_vld), 32'd0);
    checkOutput("t6_post_rx", 32'(rx_q.size()), 32'd0);
    checkOutput("t6_post_full", 32'(full), 32'd0);
    checkOutput("t6_post_af", 32'(almost_full), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h77);
    idle(4);
    checkOutput("t6_no_sop_drop", 32'(rx_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
